// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM state encoding and Z-register bus select codes
package cpu_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [4:0] BUS_SEL_ZHI  = 5'd18;
    localparam logic [4:0] BUS_SEL_ZLOW = 5'd19;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: radix-2 Booth step or non-restoring divide step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] sum;

    always_comb begin
        m_ext     = '0;
        shifted   = '0;
        sum       = acc;
        acc_next  = acc;
        q_next    = q;
        q_m1_next = 1'b0;
        if (is_div) begin
            // Divisor is a magnitude (up to 2^(W-1)), so zero-extend; add/sub chosen by the old remainder sign
            m_ext     = {1'b0, m};
            shifted   = {acc[WIDTH-1:0], q[WIDTH-1]};
            sum       = acc[WIDTH] ? shifted + m_ext : shifted - m_ext;
            acc_next  = sum;
            q_next    = {q[WIDTH-2:0], ~sum[WIDTH]};
            q_m1_next = 1'b0;
        end else begin
            m_ext = {m[WIDTH-1], m};
            case ({q[0], q_m1})
                2'b01:   sum = acc + m_ext;
                2'b10:   sum = acc - m_ext;
                default: sum = acc;
            endcase
            acc_next  = {sum[WIDTH], sum[WIDTH:1]};
            q_next    = {sum[0], q[WIDTH-1:1]};
            q_m1_next = q[0];
        end
    end

endmodule

// File: rtl/z_muldiv_unit.sv
// rtl/z_muldiv_unit.sv - multi-cycle signed multiply/divide unit writing the Z register pair
module z_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlow
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qreg;
    logic             q_m1;
    logic [WIDTH-1:0] mreg;

    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;
    logic             q_m1_next;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign busy  = (state != ST_IDLE);
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (is_div),
        .acc       (acc),
        .q         (qreg),
        .q_m1      (q_m1),
        .m         (mreg),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // With a zero divisor the remainder path reproduces |a|, so sign correction yields a itself
    always_comb begin
        rem    = acc[WIDTH] ? acc[WIDTH-1:0] + mreg : acc[WIDTH-1:0];
        fix_hi = acc[WIDTH-1:0];
        fix_lo = qreg;
        if (is_div) begin
            fix_hi = sign_a ? -rem : rem;
            if (div_by_zero)
                fix_lo = '1;
            else
                fix_lo = (sign_a ^ sign_b) ? -qreg : qreg;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= ST_IDLE;
            counter     <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            acc         <= '0;
            qreg        <= '0;
            q_m1        <= 1'b0;
            mreg        <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            zhi         <= '0;
            zlow        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        counter <= CW'(WIDTH);
                        is_div  <= (op == OP_DIV);
                        sign_a  <= a[WIDTH-1];
                        sign_b  <= b[WIDTH-1];
                        acc     <= '0;
                        q_m1    <= 1'b0;
                        if (op == OP_DIV) begin
                            qreg        <= abs_a;
                            mreg        <= abs_b;
                            div_by_zero <= (b == '0);
                        end else begin
                            qreg        <= b;
                            mreg        <= a;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    acc     <= acc_next;
                    qreg    <= q_next;
                    q_m1    <= q_m1_next;
                    counter <= counter - CW'(1);
                    if (counter == CW'(1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    zhi   <= fix_hi;
                    zlow  <= fix_lo;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z_muldiv_unit.sv
// tb/tb_z_muldiv_unit.sv - directed self-checking bench for z_muldiv_unit
module tb_z_muldiv_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] zhi;
    logic [31:0] zlow;

    int n_checks;
    int n_fail;

    z_muldiv_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .zhi         (zhi),
        .zlow        (zlow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulses start for one edge and counts edges until done is seen (100 means no done).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cycles);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 100) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        clear = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        n_checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, done, div_by_zero});
        end
        n_checks++;
        if ({zhi, zlow} !== 64'h0) begin
            n_fail++; $display("FAIL reset_z: got %h required 0", {zhi, zlow});
        end
    endtask

    task automatic test_mul;
        int cyc;
        run_op(2'b00, 32'd7, 32'hFFFFFFFD, cyc);
        n_checks++;
        if (cyc !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d required 33", cyc); end
        n_checks++;
        if ({zhi, zlow} !== 64'hFFFFFFFF_FFFFFFEB) begin
            n_fail++; $display("FAIL mul_7x-3: got %h required FFFFFFFFFFFFFFEB", {zhi, zlow});
        end
        @(posedge clock); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b required 0", done); end

        // Result registers must hold the previous value while iterating
        op = 2'b00; a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        n_checks++;
        if ({busy, zhi, zlow} !== {1'b1, 64'hFFFFFFFF_FFFFFFEB}) begin
            n_fail++; $display("FAIL hold_during_run: got busy=%b z=%h required busy=1 z=FFFFFFFFFFFFFFEB", busy, {zhi, zlow});
        end
        cyc = 10;
        while (!done && cyc < 100) begin @(posedge clock); #1; cyc++; end
        n_checks++;
        if ({zhi, zlow} !== 64'h3FFFFFFF_00000001) begin
            n_fail++; $display("FAIL mul_max_pos: got %h required 3FFFFFFF00000001", {zhi, zlow});
        end

        run_op(2'b00, 32'h80000000, 32'h80000000, cyc);
        n_checks++;
        if ({zhi, zlow} !== 64'h40000000_00000000) begin
            n_fail++; $display("FAIL mul_min_neg: got %h required 4000000000000000", {zhi, zlow});
        end
        run_op(2'b11, 32'hFFFFFFFF, 32'd5, cyc);
        n_checks++;
        if ({zhi, zlow} !== 64'hFFFFFFFF_FFFFFFFB) begin
            n_fail++; $display("FAIL mul_reserved_op: got %h required FFFFFFFFFFFFFFFB", {zhi, zlow});
        end
    endtask

    task automatic test_div;
        int cyc;
        run_op(2'b01, 32'hFFFFFFF9, 32'd2, cyc);
        n_checks++;
        if (cyc !== 33) begin n_fail++; $display("FAIL div_latency: got %0d required 33", cyc); end
        n_checks++;
        if ({zhi, zlow, div_by_zero} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) begin
            n_fail++; $display("FAIL div_-7/2: got r=%h q=%h dz=%b required r=FFFFFFFF q=FFFFFFFD dz=0", zhi, zlow, div_by_zero);
        end
        run_op(2'b01, 32'd7, 32'hFFFFFFFE, cyc);
        n_checks++;
        if ({zhi, zlow} !== {32'h00000001, 32'hFFFFFFFD}) begin
            n_fail++; $display("FAIL div_7/-2: got r=%h q=%h required r=00000001 q=FFFFFFFD", zhi, zlow);
        end
        run_op(2'b01, 32'hFFFFFF9C, 32'hFFFFFFF9, cyc);
        n_checks++;
        if ({zhi, zlow} !== {32'hFFFFFFFE, 32'h0000000E}) begin
            n_fail++; $display("FAIL div_-100/-7: got r=%h q=%h required r=FFFFFFFE q=0000000E", zhi, zlow);
        end
        run_op(2'b01, 32'd5, 32'h80000000, cyc);
        n_checks++;
        if ({zhi, zlow} !== {32'h00000005, 32'h00000000}) begin
            n_fail++; $display("FAIL div_5/min: got r=%h q=%h required r=00000005 q=00000000", zhi, zlow);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        run_op(2'b01, 32'd5, 32'd0, cyc);
        n_checks++;
        if (cyc !== 33) begin n_fail++; $display("FAIL dz_latency: got %0d required 33", cyc); end
        n_checks++;
        if ({zhi, zlow, div_by_zero} !== {32'h00000005, 32'hFFFFFFFF, 1'b1}) begin
            n_fail++; $display("FAIL div_by_zero: got r=%h q=%h dz=%b required r=00000005 q=FFFFFFFF dz=1", zhi, zlow, div_by_zero);
        end
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_sticky: got %b required 1", div_by_zero); end
        run_op(2'b00, 32'd2, 32'd3, cyc);
        n_checks++;
        if ({div_by_zero, zhi, zlow} !== {1'b0, 64'd6}) begin
            n_fail++; $display("FAIL dz_cleared: got dz=%b z=%h required dz=0 z=6", div_by_zero, {zhi, zlow});
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, cyc);
        n_checks++;
        if ({zhi, zlow, div_by_zero} !== {32'h0, 32'h80000000, 1'b0}) begin
            n_fail++; $display("FAIL div_overflow: got r=%h q=%h dz=%b required r=0 q=80000000 dz=0", zhi, zlow, div_by_zero);
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_cycle: got %b required 1", done); end
        run_op(2'b01, 32'd100, 32'd7, cyc);
        n_checks++;
        if (cyc !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d required 33", cyc); end
        n_checks++;
        if ({zhi, zlow} !== {32'd2, 32'd14}) begin
            n_fail++; $display("FAIL b2b_result: got r=%h q=%h required r=2 q=E", zhi, zlow);
        end
    endtask

    task automatic test_clear_mid;
        int dones;
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        clear = 1'b1;
        #2;
        n_checks++;
        if ({busy, done, zhi, zlow} !== {2'b00, 64'h0}) begin
            n_fail++; $display("FAIL clear_mid: got busy=%b done=%b z=%h required 0 0 0", busy, done, {zhi, zlow});
        end
        @(posedge clock); #1;
        clear = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL clear_no_done: got dones=%0d busy=%b required 0 0", dones, busy);
        end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        op = 2'b01; a = 32'd1; b = 32'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 6;
        while (!done && cyc < 100) begin @(posedge clock); #1; cyc++; end
        n_checks++;
        if (cyc !== 33) begin n_fail++; $display("FAIL busy_start_latency: got %0d required 33", cyc); end
        n_checks++;
        if ({zhi, zlow, div_by_zero} !== {32'h0, 32'd42, 1'b0}) begin
            n_fail++; $display("FAIL busy_start_result: got z=%h dz=%b required z=2A dz=0", {zhi, zlow}, div_by_zero);
        end
        repeat (40) @(posedge clock);
        #1;
        n_checks++;
        if ({busy, zlow} !== {1'b0, 32'd42}) begin
            n_fail++; $display("FAIL busy_start_not_queued: got busy=%b zlow=%h required 0 2A", busy, zlow);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_back_to_back;
        test_clear_mid;
        test_start_while_busy;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
